// File: rtl/pipeline_reg_stage_gen.sv
// Parametrised inter-stage pipeline register: DEPTH stages of valid/control/payload with
// stall, flush, control squash for invalid entries and saturating debug counters.
module pipeline_reg_stage_gen #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter int DEPTH    = 1,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EN,
    input  logic              CLR,
    input  logic              VALIDD,
    input  logic [DATA_W-1:0] DATAD,
    input  logic [CTRL_W-1:0] CTRLD,
    output logic              VALIDE,
    output logic [DATA_W-1:0] DATAE,
    output logic [CTRL_W-1:0] CTRLE,
    output logic [2:0]        OCC,
    output logic [15:0]       BUBBLE_CNT,
    output logic [15:0]       FLUSH_CNT
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
            $error("pipeline_reg_stage_gen: DEPTH must be within 1..4");
        end
    endgenerate

    function automatic logic [2:0] pop_count(input logic [DEPTH-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][CTRL_W-1:0] r_ctrl;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [2:0]                   r_occ;
    logic [15:0]                  r_bubble_cnt;
    logic [15:0]                  r_flush_cnt;

    logic [DEPTH-1:0]             w_valid_nxt;
    logic [DEPTH-1:0][CTRL_W-1:0] w_ctrl_nxt;
    logic [DEPTH-1:0][DATA_W-1:0] w_data_nxt;
    logic [DEPTH-1:0][DATA_W-1:0] w_data_shift;

    // Payload as it would look after one advance; shared by advance and data-preserving flush.
    always_comb begin
        w_data_shift    = r_data;
        w_data_shift[0] = DATAD;
        for (int k = 1; k < DEPTH; k++) begin
            w_data_shift[k] = r_data[k-1];
        end
    end

    // Next stage contents: flush beats stall, stall holds, advance shifts with control squash.
    always_comb begin
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        w_data_nxt  = r_data;
        if (CLR) begin
            w_valid_nxt = '0;
            w_ctrl_nxt  = '0;
            if (CLR_DATA) begin
                w_data_nxt = '0;
            end else begin
                w_data_nxt = w_data_shift;
            end
        end else if (EN) begin
            w_valid_nxt[0] = VALIDD;
            w_ctrl_nxt[0]  = VALIDD ? CTRLD : '0;
            w_data_nxt     = w_data_shift;
            for (int k = 1; k < DEPTH; k++) begin
                w_valid_nxt[k] = r_valid[k-1];
                w_ctrl_nxt[k]  = r_ctrl[k-1];
            end
        end else begin
            w_valid_nxt = r_valid;
            w_ctrl_nxt  = r_ctrl;
            w_data_nxt  = r_data;
        end
    end

    // Stage registers, occupancy and debug counters; OCC tracks the updated valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= '0;
            r_ctrl       <= '0;
            r_data       <= '0;
            r_occ        <= 3'd0;
            r_bubble_cnt <= 16'd0;
            r_flush_cnt  <= 16'd0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_data  <= w_data_nxt;
            r_occ   <= pop_count(w_valid_nxt);
            if (CLR) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
            if (!w_valid_nxt[DEPTH-1]) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    assign VALIDE     = r_valid[DEPTH-1];
    assign CTRLE      = r_ctrl[DEPTH-1];
    assign DATAE      = r_data[DEPTH-1];
    assign OCC        = r_occ;
    assign BUBBLE_CNT = r_bubble_cnt;
    assign FLUSH_CNT  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_reg_stage_gen.sv
// Scoreboard bench for pipeline_reg_stage_gen: a DEPTH=3/CLR_DATA=0 unit and a DEPTH=1/CLR_DATA=1
// unit share stimulus; expected outputs are queued at drive time and compared after each edge.
module tb_pipeline_reg_stage_gen;

    logic        clk;
    logic        reset;
    logic        EN;
    logic        CLR;
    logic        VALIDD;
    logic [31:0] DATAD;
    logic [7:0]  CTRLD;

    logic        a_valide, b_valide;
    logic [31:0] a_datae,  b_datae;
    logic [7:0]  a_ctrle,  b_ctrle;
    logic [2:0]  a_occ,    b_occ;
    logic [15:0] a_bub,    b_bub;
    logic [15:0] a_fl,     b_fl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [7:0]  c;
        logic [31:0] d;
        logic [2:0]  occ;
        logic [15:0] bub;
        logic [15:0] fl;
    } exp_t;

    exp_t sb_q[$];

    logic        m_v[2][4];
    logic [7:0]  m_c[2][4];
    logic [31:0] m_d[2][4];
    logic [15:0] m_bub[2];
    logic [15:0] m_fl[2];
    int          m_dep[2]  = '{3, 1};
    bit          m_clrd[2] = '{1'b0, 1'b1};

    pipeline_reg_stage_gen #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CLR_DATA(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .EN(EN), .CLR(CLR), .VALIDD(VALIDD), .DATAD(DATAD), .CTRLD(CTRLD),
        .VALIDE(a_valide), .DATAE(a_datae), .CTRLE(a_ctrle), .OCC(a_occ),
        .BUBBLE_CNT(a_bub), .FLUSH_CNT(a_fl)
    );

    pipeline_reg_stage_gen #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .CLR_DATA(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .EN(EN), .CLR(CLR), .VALIDD(VALIDD), .DATAD(DATAD), .CTRLD(CTRLD),
        .VALIDE(b_valide), .DATAE(b_datae), .CTRLE(b_ctrle), .OCC(b_occ),
        .BUBBLE_CNT(b_bub), .FLUSH_CNT(b_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the reference model of unit u by one edge using the currently driven inputs.
    task automatic step_model(input int u);
        int         dep;
        bit         clrd;
        exp_t       e;
        logic [2:0] cnt;
        dep  = m_dep[u];
        clrd = m_clrd[u];
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                m_v[u][k] = 1'b0;
                m_c[u][k] = 8'd0;
                m_d[u][k] = 32'd0;
            end
            m_bub[u] = 16'd0;
            m_fl[u]  = 16'd0;
        end else begin
            if (CLR) begin
                for (int k = dep - 1; k > 0; k--) begin
                    m_d[u][k] = clrd ? 32'd0 : m_d[u][k-1];
                end
                m_d[u][0] = clrd ? 32'd0 : DATAD;
                for (int k = 0; k < dep; k++) begin
                    m_v[u][k] = 1'b0;
                    m_c[u][k] = 8'd0;
                end
                if (m_fl[u] != 16'hFFFF) m_fl[u] = m_fl[u] + 16'd1;
            end else if (EN) begin
                for (int k = dep - 1; k > 0; k--) begin
                    m_v[u][k] = m_v[u][k-1];
                    m_c[u][k] = m_c[u][k-1];
                    m_d[u][k] = m_d[u][k-1];
                end
                m_v[u][0] = VALIDD;
                m_c[u][0] = VALIDD ? CTRLD : 8'd0;
                m_d[u][0] = DATAD;
            end
            if (!m_v[u][dep-1] && m_bub[u] != 16'hFFFF) m_bub[u] = m_bub[u] + 16'd1;
        end
        cnt = 3'd0;
        for (int k = 0; k < dep; k++) cnt = cnt + {2'b00, m_v[u][k]};
        e.v   = m_v[u][dep-1];
        e.c   = m_c[u][dep-1];
        e.d   = m_d[u][dep-1];
        e.occ = cnt;
        e.bub = m_bub[u];
        e.fl  = m_fl[u];
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string p, input logic v, input logic [7:0] c, input logic [31:0] d,
                             input logic [2:0] o, input logic [15:0] bb, input logic [15:0] ff);
        exp_t e;
        e = sb_q.pop_front();
        chk({p, ".VALIDE"},     {63'd0, v},  {63'd0, e.v});
        chk({p, ".CTRLE"},      {56'd0, c},  {56'd0, e.c});
        chk({p, ".DATAE"},      {32'd0, d},  {32'd0, e.d});
        chk({p, ".OCC"},        {61'd0, o},  {61'd0, e.occ});
        chk({p, ".BUBBLE_CNT"}, {48'd0, bb}, {48'd0, e.bub});
        chk({p, ".FLUSH_CNT"},  {48'd0, ff}, {48'd0, e.fl});
    endtask

    task automatic cycle(input logic rst_n, input logic en, input logic clr, input logic vd,
                         input logic [31:0] dd, input logic [7:0] cd);
        @(negedge clk);
        reset  = rst_n;
        EN     = en;
        CLR    = clr;
        VALIDD = vd;
        DATAD  = dd;
        CTRLD  = cd;
        step_model(0);
        step_model(1);
        @(posedge clk);
        #1;
        check_out("a", a_valide, a_ctrle, a_datae, a_occ, a_bub, a_fl);
        check_out("b", b_valide, b_ctrle, b_datae, b_occ, b_bub, b_fl);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        reset = 1'b0; EN = 1'b0; CLR = 1'b0; VALIDD = 1'b0; DATAD = 32'd0; CTRLD = 8'd0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            r = $urandom; r2 = $urandom;
            cycle(1'b0, r[0], r[1], r[2], r2, r[15:8]);
        end

        // streaming 1..4
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'(i), 8'(8'h10 + i));
            if (i == 3) begin
                chk("stream_first_data", {32'd0, a_datae}, {32'd0, 32'd1});
                chk("stream_first_bub",  {48'd0, a_bub},   {48'd0, 16'd2});
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);

        // stall with A5 inside
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hA5, 8'h5A);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD, 8'h77);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);

        // flush during stall with three valid entries
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'(10 + i), 8'(8'hC0 + i));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h99, 8'hEE);
        chk("flush_valide", {63'd0, a_valide}, 64'd0);
        chk("flush_datae",  {32'd0, a_datae},  {32'd0, 32'd11});
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);

        // control squash
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'(i + 50), 8'hFF);

        // random mix
        for (int i = 0; i < 300; i++) begin
            r = $urandom; r2 = $urandom;
            cycle((r[4:0] != 5'd0), (r[6:5] != 2'd0), (r[9:7] == 3'd0), r[10], r2, r[23:16]);
        end

        // saturate both counters with a long flush run
        for (int i = 0; i < 65540; i++) begin
            r = $urandom;
            cycle(1'b1, r[0], 1'b1, r[1], r, r[15:8]);
        end
        chk("bub_sat",   {48'd0, a_bub}, {48'd0, 16'hFFFF});
        chk("flush_sat", {48'd0, a_fl},  {48'd0, 16'hFFFF});
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'(200 + i), 8'h3C);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 8'h3C);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'(400 + i), 8'h11);

        // mid-run reset clears counters
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 8'h22);
        chk("bub_after_reset",   {48'd0, a_bub}, 64'd0);
        chk("flush_after_reset", {48'd0, a_fl},  64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'(600 + i), 8'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
